freq_meter: RTL and testbench
=============================

# freq_meter

Frequency/period measurement block on the system clock. It synchronises an asynchronous input signal and measures it in one of two modes. In frequency mode it counts rising edges over a fixed gate window. In period mode it counts clock cycles between two consecutive rising edges. It consumes the divided clocks and external test signals the divider stage produces, and reports each result over a single-cycle done handshake for display or CPU readback.

## Interface
Parameters:
- GATE_CYCLES, 50_000_000: gate window length in clk cycles (frequency mode); legal range ≥ 2.
- CNT_W, 32: width of result and internal counters; legal range 4–32.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- sig_in  input  1  asynchronous signal under measurement.
- start  input  1  request a measurement; sampled only in IDLE.
- mode  input  1  0 = frequency (edge count over gate), 1 = period (cycles per period); sampled with start.
- busy  output  1  high while in ARM or MEASURE.
- done  output  1  one-cycle pulse; result/overflow valid from this cycle.
- result  output  CNT_W  last measurement; held until next done.
- overflow  output  1  last measurement saturated or timed out; held with result.

## Operation
Input conditioning:
- sig_in passes through two flops (s1, s2), then one history flop (s3).
- rise = s2 & ~s3.
- All three flops reset to 0.

States: IDLE, ARM, MEASURE.
- IDLE: start=1 latches mode.
  - mode=0: load gate counter with GATE_CYCLES, clear edge count, go to MEASURE.
  - mode=1: clear cycle count, go to ARM.
- ARM (period mode only): cycle count increments each cycle.
  - rise: clear count, go to MEASURE.
  - Count reaches 2^CNT_W−1 with no rise: timeout.
- MEASURE, frequency mode:
  - Gate counter decrements each cycle.
  - Edge count increments on rise and saturates at 2^CNT_W−1. Any rise at saturation sets the internal ovf flag.
  - In the cycle the gate counter equals 1: result ← edge count plus rise of that cycle (saturating), overflow ← ovf, go to IDLE. MEASURE therefore lasts exactly GATE_CYCLES cycles.
- MEASURE, period mode: count increments each cycle.
  - rise: result ← count+1, overflow ← 0, go to IDLE.
  - Count reaches 2^CNT_W−1 with no rise: timeout.
- Timeout (ARM or MEASURE): result ← 2^CNT_W−1, overflow ← 1, go to IDLE.
- done is registered. It is high for exactly the first IDLE cycle after a completed measurement.

Boundary rules:
- start while busy is ignored. No abort except rst.
- start in the done cycle is accepted. The new measurement begins and result stays held until its own done.
- Frequency mode ignores edge phase: an edge in the last gate cycle is counted, and an edge after the gate closes is not counted.
- rst at any time: state IDLE, busy=0, done=0, result=0, overflow=0, all counters 0. No pending done after release.

## Timing
- Reset values: busy=0, done=0, result=0, overflow=0.
- sig_in synchroniser latency: a 0→1 input first sampled high at posedge k produces rise high during the cycle after posedge k+1, for one cycle.
- Frequency mode: start accepted at posedge t; busy is high for cycles t+1 … t+GATE_CYCLES; done is high in cycle t+GATE_CYCLES+1.
- Period mode: done follows the terminating rise by one cycle.
- Input pulses shorter than 2 clk periods may be missed. This is not an error.
- Measurable period in period mode: 2 … 2^CNT_W−2 cycles.

## Test plan
1. Frequency, GATE_CYCLES=100, sig_in period 10 clk (5 high/5 low), pulse start → busy for exactly 100 cycles, done 1 cycle, result=10, overflow=0.
2. Period, sig_in period 37 clk, mode=1, start → result=37, overflow=0; repeat with period 2 → result=2.
3. Period timeout, CNT_W=8, sig_in held 0 → done 255 cycles after start, result=255, overflow=1.
4. Frequency saturation, CNT_W=4, GATE_CYCLES=100, sig_in period 4 (25 rises) → result=15, overflow=1.
5. start pulses while busy are ignored (single done, result unchanged mid-run). start in the done cycle → a second measurement starts immediately and returns the same result.
6. rst asserted mid-MEASURE → busy, done, result and overflow all 0 asynchronously. After release, no done appears until a new start.

Source files
------------

// File: rtl/freq_meter_if.sv
// Control/result bundle for freq_meter: start/mode request and the done-qualified result.
interface freq_meter_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             mode;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] result;
    logic             overflow;

    // Requester side (CPU, display controller or testbench).
    modport master (
        output start, mode,
        input  busy, done, result, overflow
    );

    // Measurement block side.
    modport slave (
        input  start, mode,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/freq_meter.sv
// Frequency / period meter. Synchronises sig_in, then either counts rising edges
// over a fixed gate window (mode 0) or counts clk cycles between two consecutive
// rising edges (mode 1). Each result is announced with a one-cycle done pulse and
// held until the next one.
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sig_in,
    freq_meter_if.slave  bus
);
    localparam int GW = $clog2(GATE_CYCLES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES);

    logic             s1_q, s2_q, s3_q;
    logic             rise;

    logic [1:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] edge_cnt;
    logic             edge_ovf;
    logic             cnt_hits_max;

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the pre-edge values; blocking here would collapse the chain into one stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    // Shared arithmetic: plain increment, saturating edge count and its overflow.
    always_comb begin
        cnt_inc      = cnt_q + CNT_W'(1);
        cnt_hits_max = (cnt_inc == CNT_MAX);
        edge_cnt     = (rise && (cnt_q != CNT_MAX)) ? cnt_inc : cnt_q;
        edge_ovf     = ovf_q | (rise & (cnt_q == CNT_MAX));
    end

    // Measurement FSM: next-state, counters and result capture.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        mode_d     = mode_q;
        gate_d     = gate_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    if (bus.mode) begin
                        state_d = S_ARM;
                    end else begin
                        gate_d  = GATE_LOAD;
                        state_d = S_MEAS;
                    end
                end
            end

            S_ARM: begin
                if (rise) begin
                    // First edge opens the period; counting restarts from it.
                    cnt_d   = '0;
                    state_d = S_MEAS;
                end else if (cnt_hits_max) begin
                    result_d   = CNT_MAX;
                    overflow_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_MEAS: begin
                if (!mode_q) begin
                    gate_d = gate_q - GW'(1);
                    cnt_d  = edge_cnt;
                    ovf_d  = edge_ovf;
                    if (gate_q == GW'(1)) begin
                        // Last gate cycle: its own edge is included in the result.
                        result_d   = edge_cnt;
                        overflow_d = edge_ovf;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else if (rise) begin
                    result_d   = cnt_inc;
                    overflow_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end else if (cnt_hits_max) begin
                    result_d   = CNT_MAX;
                    overflow_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and result registers; reset clears everything including any pending done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            gate_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            gate_q     <= gate_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: two instances (8-bit and 4-bit counters,
// 100-cycle gate) driven from a shared periodic sig_in generator; results are
// scoreboarded through per-instance queues of expected values.
module tb_freq_meter;
    localparam int GATE = 100;

    typedef struct packed {
        logic [7:0] result;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic sig_in;

    int checks = 0;
    int errors = 0;

    int sig_per = 0;   // 0 holds sig_in low
    int sig_hi  = 0;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t e_a, e_b;

    always #5 clk = ~clk;

    freq_meter_if #(.CNT_W(8)) bus_a ();
    freq_meter_if #(.CNT_W(4)) bus_b ();

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .sig_in(sig_in), .bus(bus_a)
    );
    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .sig_in(sig_in), .bus(bus_b)
    );

    // Periodic test signal, updated 1 time unit after each rising edge.
    initial begin
        int ph;
        ph = 0;
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sig_per == 0) begin
                sig_in = 1'b0;
                ph = 0;
            end else begin
                sig_in = (ph < sig_hi);
                ph = (ph + 1 >= sig_per) ? 0 : ph + 1;
            end
        end
    end

    // Scoreboard for instance A.
    always @(negedge clk) begin
        if (!rst && bus_a.done === 1'b1) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL done_a_unexpected: result=%0d overflow=%0b, required no done", bus_a.result, bus_a.overflow);
            end else begin
                e_a = exp_a.pop_front();
                if ({bus_a.result, bus_a.overflow} !== {e_a.result, e_a.ovf}) begin
                    errors++;
                    $display("FAIL result_a: got %0d/%0b, required %0d/%0b", bus_a.result, bus_a.overflow, e_a.result, e_a.ovf);
                end
            end
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        if (!rst && bus_b.done === 1'b1) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL done_b_unexpected: result=%0d overflow=%0b, required no done", bus_b.result, bus_b.overflow);
            end else begin
                e_b = exp_b.pop_front();
                if ({4'b0000, bus_b.result, bus_b.overflow} !== {e_b.result, e_b.ovf}) begin
                    errors++;
                    $display("FAIL result_b: got %0d/%0b, required %0d/%0b", bus_b.result, bus_b.overflow, e_b.result, e_b.ovf);
                end
            end
        end
    end

    task automatic pulse_start_a(input logic m);
        @(negedge clk);
        bus_a.mode  = m;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
    endtask

    task automatic pulse_start_b(input logic m);
        @(negedge clk);
        bus_b.mode  = m;
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
    endtask

    // Returns at the negedge where done is seen (or after the limit), counting busy cycles.
    task automatic wait_done_a(input int limit, output int busy_n, output bit seen);
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus_a.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus_a.busy === 1'b1) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done_b(input int limit, output int busy_n, output bit seen);
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus_b.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus_b.busy === 1'b1) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.mode = 1'b0;
        bus_b.start = 1'b0; bus_b.mode = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_a.busy, bus_a.done, bus_a.result, bus_a.overflow} !== 11'd0) begin
            errors++;
            $display("FAIL reset_a: busy=%b done=%b result=%0d ovf=%b, required all 0", bus_a.busy, bus_a.done, bus_a.result, bus_a.overflow);
        end
        checks++;
        if ({bus_b.busy, bus_b.done, bus_b.result, bus_b.overflow} !== 7'd0) begin
            errors++;
            $display("FAIL reset_b: busy=%b done=%b result=%0d ovf=%b, required all 0", bus_b.busy, bus_b.done, bus_b.result, bus_b.overflow);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frequency();
        int busy_n;
        bit seen;
        sig_per = 10; sig_hi = 5;
        repeat (20) @(negedge clk);
        exp_a.push_back(exp_t'{result: 8'd10, ovf: 1'b0});
        pulse_start_a(1'b0);
        wait_done_a(500, busy_n, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL freq_done_timeout: no done within 500 cycles, required done");
        end
        checks++;
        if (busy_n != GATE) begin
            errors++;
            $display("FAIL freq_busy_len: got %0d cycles, required %0d", busy_n, GATE);
        end
        checks++;
        if (bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL freq_busy_at_done: got %b, required 0", bus_a.busy);
        end
        @(negedge clk);
        checks++;
        if (bus_a.done !== 1'b0) begin
            errors++;
            $display("FAIL freq_done_width: done still %b one cycle later, required 0", bus_a.done);
        end
    endtask

    task automatic test_period();
        int busy_n;
        bit seen;
        sig_per = 37; sig_hi = 18;
        repeat (50) @(negedge clk);
        exp_a.push_back(exp_t'{result: 8'd37, ovf: 1'b0});
        pulse_start_a(1'b1);
        wait_done_a(500, busy_n, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL period37_timeout: no done within 500 cycles, required done");
        end
        sig_per = 2; sig_hi = 1;
        repeat (10) @(negedge clk);
        exp_a.push_back(exp_t'{result: 8'd2, ovf: 1'b0});
        pulse_start_a(1'b1);
        wait_done_a(100, busy_n, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL period2_timeout: no done within 100 cycles, required done");
        end
    endtask

    task automatic test_timeout();
        int busy_n;
        bit seen;
        sig_per = 0;
        repeat (10) @(negedge clk);
        exp_a.push_back(exp_t'{result: 8'd255, ovf: 1'b1});
        pulse_start_a(1'b1);
        wait_done_a(400, busy_n, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_done: no done within 400 cycles, required done");
        end
        checks++;
        if (busy_n != 255) begin
            errors++;
            $display("FAIL timeout_busy_len: got %0d cycles, required 255", busy_n);
        end
    endtask

    task automatic test_saturation();
        int busy_n;
        bit seen;
        sig_per = 4; sig_hi = 2;
        repeat (10) @(negedge clk);
        exp_b.push_back(exp_t'{result: 8'd15, ovf: 1'b1});
        pulse_start_b(1'b0);
        wait_done_b(500, busy_n, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL sat_done: no done within 500 cycles, required done");
        end
        checks++;
        if (busy_n != GATE) begin
            errors++;
            $display("FAIL sat_busy_len: got %0d cycles, required %0d", busy_n, GATE);
        end
    endtask

    task automatic test_back_to_back();
        int busy_n;
        bit seen;
        sig_per = 10; sig_hi = 5;
        repeat (20) @(negedge clk);
        exp_a.push_back(exp_t'{result: 8'd10, ovf: 1'b0});
        pulse_start_a(1'b0);
        busy_n = 0;
        seen   = 1'b0;
        // Extra start pulses (period mode requested) land while busy and must be ignored.
        for (int i = 0; i < 500; i++) begin
            if (bus_a.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus_a.busy === 1'b1) busy_n++;
            if (i == 20 || i == 50 || i == 80) begin
                checks++;
                if ({bus_a.result, bus_a.overflow} !== {8'd255, 1'b1}) begin
                    errors++;
                    $display("FAIL b2b_held_mid: got %0d/%0b, required 255/1", bus_a.result, bus_a.overflow);
                end
                bus_a.mode  = 1'b1;
                bus_a.start = 1'b1;
            end else begin
                bus_a.start = 1'b0;
            end
            @(negedge clk);
        end
        bus_a.start = 1'b0;
        checks++;
        if (!seen || busy_n != GATE) begin
            errors++;
            $display("FAIL b2b_ignore_start: seen=%0b busy=%0d cycles, required done after %0d", seen, busy_n, GATE);
        end
        // Start in the done cycle.
        exp_a.push_back(exp_t'{result: 8'd10, ovf: 1'b0});
        bus_a.mode  = 1'b0;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        checks++;
        if (bus_a.busy !== 1'b1 || bus_a.result !== 8'd10) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b result=%0d, required busy=1 result=10", bus_a.busy, bus_a.result);
        end
        wait_done_a(500, busy_n, seen);
        checks++;
        if (!seen || busy_n != GATE) begin
            errors++;
            $display("FAIL b2b_second: seen=%0b busy=%0d cycles, required done after %0d", seen, busy_n, GATE);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        sig_per = 10; sig_hi = 5;
        pulse_start_a(1'b0);
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus_a.busy, bus_a.done, bus_a.result, bus_a.overflow} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_async: busy=%b done=%b result=%0d ovf=%b, required all 0", bus_a.busy, bus_a.done, bus_a.result, bus_a.overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1 || bus_a.busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: %0d busy/done cycles after release, required 0", dones);
        end
    endtask

    initial begin
        test_reset();
        test_frequency();
        test_period();
        test_timeout();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d results outstanding, required 0/0", exp_a.size(), exp_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
